bram_burst_port: RTL and testbench
==================================

BRAM_BURST_PORT -- requirements
Module: bram_burst_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, BRAM word-address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, burst length field width.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port: req_valid  input  1  burst request present.
REQ-008 SHALL have port: req_ready  output  1  request accepted when both high.
REQ-009 SHALL have port: req_write  input  1  1 = write burst, 0 = read burst.
REQ-010 SHALL have port: req_addr  input  ADDR_WIDTH  first word address.
REQ-011 SHALL have port: req_len  input  LEN_WIDTH  beats minus one.
REQ-012 SHALL have port: wdata_valid / wdata_ready  input / output  1 each  write-beat handshake.
REQ-013 SHALL have port: wdata  input  DATA_WIDTH  write beat; wstrb  input  DATA_WIDTH/8  byte enables.
REQ-014 SHALL have port: rdata_valid / rdata_ready  output / input  1 each  read-beat handshake.
REQ-015 SHALL have port: rdata  output  DATA_WIDTH  read beat; rdata_last  output  1  final beat flag.
REQ-016 SHALL have port: done  output  1  one-cycle pulse at burst completion.
REQ-017 SHALL have port: bram_en  output  1, bram_write_en  output  DATA_WIDTH/8, bram_addr  output  ADDR_WIDTH, bram_data_in  output  DATA_WIDTH, bram_data_out  input  DATA_WIDTH; connects to one port of the 1-cycle-latency dual-port BRAM.

Function
REQ-018 SHALL implement states IDLE, CLEAR (macro only), READ, WRITE; req_ready=1 only in IDLE.
REQ-019 SHALL on request handshake latch addr/len/direction and enter READ or WRITE next cycle.
REQ-020 SHALL in WRITE drive wdata_ready=1; each wdata handshake drives bram_en=1, bram_write_en=wstrb, bram_addr=current address, bram_data_in=wdata in the same cycle.
REQ-021 SHALL in READ issue a read (bram_en=1, bram_write_en=0) when beats remain and (rdata_valid=0 or rdata_ready=1); rdata_valid SHALL rise exactly one cycle after issue.
REQ-022 SHALL drive rdata combinationally from bram_data_out and hold bram_en=0 while stalled, so that rdata is stable under backpressure.
REQ-023 SHALL sustain one beat per cycle in both directions when the partner is always ready.
REQ-024 SHALL assert rdata_last together with rdata_valid on beat req_len+1 only.
REQ-025 SHALL increment the address modulo 2^ADDR_WIDTH (0x3FF -> 0x000 at default).
REQ-026 SHALL return to IDLE and pulse done for one cycle after the last write beat handshake or the last read beat handshake; req_ready SHALL be 1 in the cycle after done.
REQ-027 SHALL drive bram_en=0 and bram_write_en=0 in IDLE and on every cycle without an active access.
REQ-028 SHALL ignore wdata_valid outside WRITE (wdata_ready=0).

Reset
REQ-029 SHALL on reset, including mid-burst, abort the burst without completing it and enter IDLE (CLEAR if macro defined) on the next cycle.
REQ-030 SHALL force reset values: req_ready=0 during reset cycle, wdata_ready=0, rdata_valid=0, rdata_last=0, done=0, bram_en=0, bram_write_en=0, bram_addr=0, bram_data_in=0.

Configuration
REQ-031 SHALL honour macro BRAM_BURST_CLEAR_EN: when defined, after reset enter CLEAR and write zero with all byte enables to addresses 0 .. 2^ADDR_WIDTH-1, one per cycle, then IDLE; req_ready=0 throughout CLEAR.
REQ-032 SHALL, without BRAM_BURST_CLEAR_EN, go directly to IDLE after reset and leave BRAM contents untouched.

Verification
REQ-033 SHALL be verified by: write burst addr=0x010 len=3 data 0xA0..0xA3 -> 4 consecutive BRAM writes at 0x010..0x013, done pulse one cycle after the last beat.
REQ-034 SHALL be verified by: read burst addr=0x010 len=3 with rdata_ready=1 -> rdata 0xA0..0xA3 on 4 consecutive cycles, rdata_last on 0xA3 only.
REQ-035 SHALL be verified by: same read with rdata_ready low for 3 cycles on beat 2 -> rdata holds 0xA1 stable, bram_en=0 during stall, no beat lost or duplicated.
REQ-036 SHALL be verified by: write burst addr=0x3FE len=3 -> writes at 0x3FE, 0x3FF, 0x000, 0x001.
REQ-037 SHALL be verified by: reset asserted after beat 2 of a len=7 read -> next cycle rdata_valid=0, bram_en=0, state IDLE; a new request is accepted.
REQ-038 SHALL be verified with BRAM_BURST_CLEAR_EN defined: after reset, req_ready=0 for exactly 1024 cycles, and a subsequent read of 0x3FF returns 0.

Source files
------------

// File: rtl/bram_burst_port_if.sv
// bram_burst_port_if: request, write-beat, read-beat and BRAM-port signals of bram_burst_port.
interface bram_burst_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [LEN_WIDTH-1:0]    req_len;
    logic                    wdata_valid;
    logic                    wdata_ready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    rdata_valid;
    logic                    rdata_ready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rdata_last;
    logic                    done;
    logic                    bram_en;
    logic [DATA_WIDTH/8-1:0] bram_write_en;
    logic [ADDR_WIDTH-1:0]   bram_addr;
    logic [DATA_WIDTH-1:0]   bram_data_in;
    logic [DATA_WIDTH-1:0]   bram_data_out;
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, wstrb,
               rdata_ready, bram_data_out,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
               bram_en, bram_write_en, bram_addr, bram_data_in
    );
    modport master (
        output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, wstrb,
               rdata_ready, bram_data_out,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
               bram_en, bram_write_en, bram_addr, bram_data_in
    );
endinterface

// File: rtl/bram_burst_port.sv
// bram_burst_port: burst read/write engine for one port of a 1-cycle-latency BRAM.
// Define BRAM_BURST_CLEAR_EN to zero the whole BRAM after every reset.
module bram_burst_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
) (
    input logic              clk,
    input logic              reset,
    bram_burst_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, READ, WRITE} state_t;
`ifdef BRAM_BURST_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = IDLE;
`endif
    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr, addr_nx;
    logic [LEN_WIDTH-1:0]  cnt, cnt_nx;
    logic                  issued_all, issued_all_nx;
    logic                  rvalid, rvalid_nx, rlast, rlast_nx, done_q, done_nx;
    logic                  r_hs;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RST_STATE;
            addr       <= '0;
            cnt        <= '0;
            issued_all <= 1'b1;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            addr       <= addr_nx;
            cnt        <= cnt_nx;
            issued_all <= issued_all_nx;
            rvalid     <= rvalid_nx;
            rlast      <= rlast_nx;
            done_q     <= done_nx;
        end
    end
    always_comb begin
        state_nx           = state;
        addr_nx            = addr;
        cnt_nx             = cnt;
        issued_all_nx      = issued_all;
        rvalid_nx          = rvalid;
        rlast_nx           = rlast;
        done_nx            = 1'b0;
        bus.req_ready      = 1'b0;
        bus.wdata_ready    = 1'b0;
        bus.bram_en        = 1'b0;
        bus.bram_write_en  = '0;
        bus.bram_addr      = '0;
        bus.bram_data_in   = {DATA_WIDTH{1'b0}};
        r_hs               = rvalid && bus.rdata_ready;
        if (r_hs) begin
            rvalid_nx = 1'b0;
            rlast_nx  = 1'b0;
        end
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nx      = bus.req_write ? WRITE : READ;
                    addr_nx       = bus.req_addr;
                    cnt_nx        = bus.req_len;
                    issued_all_nx = 1'b0;
                end
            end
            CLEAR: begin
`ifdef BRAM_BURST_CLEAR_EN
                bus.bram_en       = 1'b1;
                bus.bram_write_en = '1;
                bus.bram_addr     = addr;
                addr_nx           = addr + 1'b1;
                state_nx          = &addr ? IDLE : CLEAR;
`endif
            end
            WRITE: begin
                bus.wdata_ready = 1'b1;
                if (bus.wdata_valid) begin
                    bus.bram_en       = 1'b1;
                    bus.bram_write_en = bus.wstrb;
                    bus.bram_addr     = addr;
                    bus.bram_data_in  = bus.wdata;
                    addr_nx           = addr + 1'b1;
                    cnt_nx            = cnt - 1'b1;
                    state_nx          = cnt == '0 ? IDLE : WRITE;
                    done_nx           = cnt == '0;
                end
            end
            READ: begin
                // a new read only when the output slot is empty or being drained, so rdata never changes under a stall
                if (!issued_all && (!rvalid || bus.rdata_ready)) begin
                    bus.bram_en   = 1'b1;
                    bus.bram_addr = addr;
                    addr_nx       = addr + 1'b1;
                    cnt_nx        = cnt - 1'b1;
                    issued_all_nx = cnt == '0;
                    rvalid_nx     = 1'b1;
                    rlast_nx      = cnt == '0;
                end
                if (r_hs && rlast) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: ;
        endcase
        if (reset) begin
            bus.req_ready     = 1'b0;
            bus.wdata_ready   = 1'b0;
            bus.bram_en       = 1'b0;
            bus.bram_write_en = '0;
            bus.bram_addr     = '0;
            bus.bram_data_in  = {DATA_WIDTH{1'b0}};
        end
    end
    assign bus.rdata_valid = rvalid;
    assign bus.rdata_last  = rlast;
    assign bus.rdata       = bus.bram_data_out;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_bram_burst_port.sv
// tb_bram_burst_port: randomized bursts against a behavioural memory reference, plus directed corner cases.
module tb_bram_burst_port;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    bram_burst_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(4)) bus ();
    bram_burst_port #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency BRAM port, read-before-write
    always @(posedge clk) begin
        if (bus.bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.bram_write_en[b]) mem[bus.bram_addr][8*b +: 8] <= bus.bram_data_in[8*b +: 8];
            bus.bram_data_out <= mem[bus.bram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic post_reset();
`ifdef BRAM_BURST_CLEAR_EN
        int n = 0;
        while (!bus.req_ready && n < 2000) begin
            n++;
            @(negedge clk); #1;
        end
        check("clear_cycles", n, 1024);
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
`else
        check("post_rst_ready", bus.req_ready, 1);
`endif
    endtask

    task automatic request(input logic wr, input logic [9:0] a, input logic [3:0] len);
        int t = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_len   = len;
        #1;
        while (!bus.req_ready && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check("req_accept", bus.req_ready, 1);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [3:0] len, input logic [31:0] base, input bit rnd);
        logic [31:0] d;
        logic [3:0]  s;
        logic [9:0]  ea;
        request(1'b1, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                bus.req_valid   = 1'b0;
                bus.wdata_valid = 1'b0;
                #1;
                check("wr_gap_en", bus.bram_en, 0);
                check("wr_gap_ready", bus.wdata_ready, 1);
            end
            d  = rnd ? $urandom : base + 32'(i);
            s  = rnd ? 4'($urandom) : 4'hF;
            ea = a + 10'(i);
            @(negedge clk);
            bus.req_valid   = 1'b0;
            bus.wdata_valid = 1'b1;
            bus.wdata       = d;
            bus.wstrb       = s;
            #1;
            check("wr_ready", bus.wdata_ready, 1);
            check("wr_en", bus.bram_en, 1);
            check("wr_we", bus.bram_write_en, s);
            check("wr_addr", bus.bram_addr, ea);
            check("wr_din", bus.bram_data_in, d);
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[ea][8*b +: 8] = d[8*b +: 8];
        end
        @(negedge clk);
        bus.wdata_valid = 1'b0;
        #1;
        check("wr_done", bus.done, 1);
        check("wr_idle", bus.req_ready, 1);
        check("wr_done_en", bus.bram_en, 0);
        @(negedge clk); #1;
        check("wr_done_pulse", bus.done, 0);
    endtask

    // mode 0: always ready, 1: ready low 3 cycles on second beat, 2: random backpressure
    task automatic do_read(input logic [9:0] a, input logic [3:0] len, input int mode);
        int k = 0, cyc = 0, first = -1, last = 0, st = 0;
        logic rdy;
        logic [9:0] ea;
        request(1'b0, a, len);
        while (k <= int'(len) && cyc < 200) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            rdy = mode == 2 ? ($urandom_range(0, 3) != 0) : !(mode == 1 && k == 1 && st < 3 && bus.rdata_valid);
            if (mode == 1 && !rdy) st++;
            bus.rdata_ready = rdy;
            #1;
            ea = a + 10'(k);
            if (bus.rdata_valid) begin
                if (first < 0) first = cyc;
                check("rd_data", bus.rdata, ref_mem[ea]);
                check("rd_last", bus.rdata_last, k == int'(len));
                if (rdy) begin
                    k++;
                    last = cyc;
                end else check("rd_stall_en", bus.bram_en, 0);
            end else if (mode == 0 && first >= 0) check("rd_valid", bus.rdata_valid, 1);
            cyc++;
        end
        check("rd_beats", k, int'(len) + 1);
        if (mode == 0) begin
            check("rd_first_lat", first, 1);
            check("rd_tput", last - first, int'(len));
        end
        if (mode == 1) check("rd_stall_cycles", st, 3);
        @(negedge clk);
        bus.rdata_ready = 1'b1;
        #1;
        check("rd_done", bus.done, 1);
        check("rd_idle", bus.req_ready, 1);
        check("rd_valid_clr", bus.rdata_valid, 0);
    endtask

    initial begin
        int k, t;
        logic [9:0] a;
        logic [3:0] len;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = '0;
        bus.req_len      = '0;
        bus.wdata_valid  = 1'b0;
        bus.wdata        = '0;
        bus.wstrb        = '0;
        bus.rdata_ready  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        @(negedge clk); #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_wdata_ready", bus.wdata_ready, 0);
        check("rst_rdata_valid", bus.rdata_valid, 0);
        check("rst_rdata_last", bus.rdata_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_bram_en", bus.bram_en, 0);
        check("rst_bram_we", bus.bram_write_en, 0);
        check("rst_bram_addr", bus.bram_addr, 0);
        check("rst_bram_din", bus.bram_data_in, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        post_reset();
        do_read(10'h3FF, 4'd0, 0);

        @(negedge clk);
        bus.wdata_valid = 1'b1;
        #1;
        check("idle_wdata_ready", bus.wdata_ready, 0);
        check("idle_bram_en", bus.bram_en, 0);
        bus.wdata_valid = 1'b0;

        do_write(10'h010, 4'd3, 32'hA0, 1'b0);
        do_read(10'h010, 4'd3, 0);
        do_read(10'h010, 4'd3, 1);
        do_write(10'h3FE, 4'd3, 32'hB0, 1'b0);
        do_read(10'h3FE, 4'd3, 0);

        for (int r = 0; r < 12; r++) begin
            a   = 10'($urandom);
            len = 4'($urandom);
            do_write(a, len, 32'h0, 1'b1);
            do_read(a, len, 2);
            do_read(10'($urandom), 4'($urandom), r % 3);
        end

        request(1'b0, 10'h010, 4'd7);
        k = 0;
        t = 0;
        while (k < 2 && t < 50) begin
            @(negedge clk);
            bus.req_valid   = 1'b0;
            bus.rdata_ready = 1'b1;
            #1;
            if (bus.rdata_valid) k++;
            t++;
        end
        check("mid_beats", k, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", bus.req_ready, 0);
        check("mid_rst_en", bus.bram_en, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_valid", bus.rdata_valid, 0);
        check("mid_last", bus.rdata_last, 0);
        check("mid_en", bus.bram_en, 0);
        check("mid_done", bus.done, 0);
        post_reset();
        do_read(10'h010, 4'd3, 0);
        do_write(10'h020, 4'd1, 32'hC0, 1'b0);
        do_read(10'h020, 4'd1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end
endmodule
